// File: rtl/ahb_apb_bridge_ctrl_if.sv
// ahb_apb_bridge_ctrl_if: AHB slave-side and APB master-side signals of the bridge controller
interface ahb_apb_bridge_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic                  hsel;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [ADDR_W-1:0]     haddr;
  logic [DATA_W-1:0]     hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_W-1:0]     hrdata;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;
  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, hready, prdata, pready, pslverr,
    output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
  );
  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, hready, prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// ahb_apb_bridge_ctrl: AHB-to-APB transfer sequencer; define APB_TIMEOUT_EN for the ACCESS-phase timeout
module ahb_apb_bridge_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic hclk,
  input  logic hreset,
  ahb_apb_bridge_ctrl_if.slave bus
`ifdef APB_TIMEOUT_EN
  ,
  output logic timeout_flag
`endif
);
  localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [2:0] {IDLE, CAPT, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
  state_t                r_state, w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_write;
  logic [SEL_W-1:0]      r_idx;
  logic                  r_hreadyout, r_hresp, r_penable, r_pwrite;
  logic [DATA_W-1:0]     r_hrdata, r_pwdata;
  logic [NUM_SLAVES-1:0] r_psel, w_psel;
  logic [ADDR_W-1:0]     r_paddr;
  logic                  w_hreadyout, w_hresp, w_penable;
  logic                  w_accept, w_mapped, w_expire;
  logic                  w_unused_htrans;
  assign w_unused_htrans = bus.htrans[0];
  assign w_accept = bus.hsel & bus.htrans[1] & bus.hready & (r_state inside {IDLE, DONE, ERR2});
  if (NUM_SLAVES == 2 ** SEL_W) begin : g_full
    assign w_mapped = 1'b1;
  end else begin : g_part
    assign w_mapped = r_idx < SEL_W'(NUM_SLAVES);
  end
`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_tcnt;
  logic             r_tflag;
  assign w_expire = r_state == ACCESS && !bus.pready && r_tcnt == CNT_W'(TIMEOUT_CYC - 1);
  assign timeout_flag = r_tflag;
  // Count stalled ACCESS cycles per transfer; the flag is sticky until reset
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_tcnt  <= '0;
      r_tflag <= 1'b0;
    end else begin
      r_tcnt  <= w_next == SETUP ? '0 : (r_state == ACCESS && !bus.pready) ? r_tcnt + 1'b1 : r_tcnt;
      r_tflag <= r_tflag | w_expire;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYC == 0;
  assign w_expire = 1'b0;
`endif
  // State register
  always_ff @(posedge hclk) begin
    if (hreset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Next-state decode; pready beats a same-cycle timeout expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR2: w_next = w_accept ? CAPT : IDLE;
      CAPT:             w_next = w_mapped ? SETUP : ERR1;
      SETUP:            w_next = ACCESS;
      ACCESS:           w_next = bus.pready ? (bus.pslverr ? ERR1 : DONE) : w_expire ? ERR1 : ACCESS;
      ERR1:             w_next = ERR2;
      default:          w_next = IDLE;
    endcase
  end
  // Output values for the coming state, registered below so every output is a flop
  always_comb begin
    w_hreadyout = w_next inside {IDLE, DONE, ERR2};
    w_hresp     = w_next inside {ERR1, ERR2};
    w_psel      = w_next inside {SETUP, ACCESS} ? NUM_SLAVES'(1) << r_idx : '0;
    w_penable   = w_next == ACCESS;
  end
  // Output and datapath registers: address phase latch, write data capture, read data return
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_hreadyout <= w_hreadyout;
      r_hresp     <= w_hresp;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      if (w_accept) begin
        r_addr  <= bus.haddr;
        r_write <= bus.hwrite;
        r_idx   <= bus.haddr[SLV_SEL_LSB +: SEL_W];
      end
      if (r_state == CAPT && r_write) r_pwdata <= bus.hwdata;
      if (w_next == SETUP) begin
        r_paddr  <= r_addr;
        r_pwrite <= r_write;
      end
      if (r_state == ACCESS && bus.pready && !r_pwrite) r_hrdata <= bus.prdata;
    end
  end
  assign bus.hreadyout = r_hreadyout;
  assign bus.hresp     = r_hresp;
  assign bus.hrdata    = r_hrdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
endmodule

// File: doc/ahb_apb_bridge_ctrl.md
Name: ahb_apb_bridge_ctrl

Overview:
- Sequencing controller on the slave side of the AHB-to-APB bridge, behind the AHB master arbiter.
- Accepts one AHB transfer at a time and decodes the target APB slave.
- Runs the APB SETUP/ACCESS protocol, then returns read data and response to AHB with wait states and the two-cycle AHB ERROR response.

Parameters:
- ADDR_W, 32, address width (haddr, paddr).
- DATA_W, 32, data width (hwdata, hrdata, pwdata, prdata).
- NUM_SLAVES, 4, number of APB slaves, 1..16.
- SLV_SEL_LSB, 12, LSB of the haddr field that selects the slave; field width is clog2(NUM_SLAVES), minimum 1.
- TIMEOUT_CYC, 16, ACCESS-phase cycle limit. Used only with APB_TIMEOUT_EN.

Ports:
- hclk  in  1  bridge clock; all logic on its rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  bridge selected by the AHB decoder.
- htrans  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ.
- hwrite  in  1  1 = write.
- haddr  in  ADDR_W  AHB address.
- hwdata  in  DATA_W  AHB write data, valid in the data phase.
- hready  in  1  bus-level HREADY.
- hreadyout  out  1  bridge ready to AHB.
- hresp  out  1  1 = ERROR.
- hrdata  out  DATA_W  read data to AHB.
- psel  out  NUM_SLAVES  one-hot APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  muxed read data from the selected slave.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; state IDLE. All outputs are registered.
- Accept condition: hsel & htrans[1] & hready & state in {IDLE, DONE, ERR2}. On accept, latch haddr, hwrite and slave index. htrans IDLE/BUSY are ignored and leave the state unchanged.
- IDLE: hreadyout=1. On accept: go to CAPT; hreadyout=0 from the next cycle.
- CAPT (1 cycle): pwdata<=hwdata for writes, held otherwise.
  - Slave index < NUM_SLAVES: go to SETUP.
  - Slave index >= NUM_SLAVES (unmapped): go to ERR1 with no APB access.
- SETUP (1 cycle): psel[index]=1, penable=0, paddr/pwrite from the latched values. Next state ACCESS.
- ACCESS: psel held, penable=1; wait while pready=0. On pready=1:
  - psel and penable go to 0.
  - Read: hrdata<=prdata.
  - pslverr=0: go to DONE. pslverr=1: go to ERR1.
- DONE (1 cycle): hreadyout=1, hresp=0. An accept in this cycle goes to CAPT (back-to-back); otherwise go to IDLE.
- ERR1: hreadyout=0, hresp=1. Next state ERR2.
- ERR2: hreadyout=1, hresp=1. Next state CAPT on accept, else IDLE. hresp returns to 0 on leaving ERR2.
- Latency: minimum 4 wait-free cycles from accept to hreadyout=1 (CAPT, SETUP, ACCESS, DONE). Each pready=0 cycle adds 1.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- Writes leave hrdata unchanged.
- Reset mid-transfer: every output returns to its reset value at the next edge and the transfer is dropped. No error is signalled.
- pready/pslverr outside ACCESS are ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: a counter of width clog2(TIMEOUT_CYC+1) clears on entry to SETUP and increments every ACCESS cycle with pready=0. When it reaches TIMEOUT_CYC:
  - psel and penable drop;
  - state goes to ERR1 (AHB ERROR);
  - a sticky output timeout_flag (1 bit, reset 0) is set and cleared only by reset.
  - pready arriving in the same cycle as expiry wins; the transfer completes normally.
- Not defined: ACCESS waits indefinitely, and neither the counter nor the timeout_flag port exists.

Test Plan:
- Single write: haddr=0x0000_1004 with SLV_SEL_LSB=12 → psel=4'b0010. hwdata=0xA5A5_0001, pready=1 → pwdata/paddr correct during SETUP+ACCESS; hreadyout=1 exactly 4 cycles after accept; hresp=0.
- Read with 3 wait states: haddr=0x0000_3010, prdata=0x1234_5678 with pready asserted on the 4th ACCESS cycle → psel=4'b1000; hrdata=0x1234_5678 when hreadyout returns to 1, 7 cycles after accept.
- Slave error: write with pslverr=1 on the pready cycle → ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), then hresp=0.
- Back-to-back: second NONSEQ presented during DONE → accepted without passing through IDLE; both APB transfers complete with correct psel.
- Reset in ACCESS with pready=0: hreset=1 for 1 cycle → psel=0, penable=0, hreadyout=1 next edge; a subsequent transfer completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYC=16, pready held 0 → after 16 ACCESS cycles psel/penable drop, ERROR response, timeout_flag=1.
